// File: rtl/vga_pkg.sv
// -----------------------------------------------------------------------------
// vga_pkg
// Shared constants for the VGA sprite engine: default geometry, colour codes
// and a small helper used by the collision logic.
// Used by: vga_sprite_engine, sprite_rom.
// -----------------------------------------------------------------------------
package vga_pkg;

   localparam int DEF_SPRITE_W = 16;
   localparam int DEF_SPRITE_H = 16;
   localparam int DEF_COORD_W  = 10;

   localparam logic [2:0] BLACK = 3'b000;
   localparam logic [2:0] WHITE = 3'b111;

   // True when two or more bits of the vector are set (clearing the lowest
   // set bit leaves something behind). Callers zero-extend to 32 bits.
   function automatic logic multi_hot(input logic [31:0] vec);
      return (vec & (vec - 32'd1)) != 32'd0;
   endfunction

endpackage

// File: rtl/sprite_rom.sv
// -----------------------------------------------------------------------------
// sprite_rom
// Combinational bitmap store shared by all sprites. Bit 0 of each word is the
// leftmost pixel of that row. The table is 16x16; other sprite sizes truncate
// or zero-extend each word and repeat rows modulo 16.
// Ports:
//   row_i  [ROW_W-1:0]    row index inside the sprite
//   word_o [SPRITE_W-1:0] pixel mask for that row
// -----------------------------------------------------------------------------
module sprite_rom
   import vga_pkg::*;
#(
   parameter int SPRITE_W = DEF_SPRITE_W,
   parameter int SPRITE_H = DEF_SPRITE_H,
   parameter int ROW_W    = (SPRITE_H > 1) ? $clog2(SPRITE_H) : 1
) (
   input  logic [ROW_W-1:0]    row_i,
   output logic [SPRITE_W-1:0] word_o
);

   logic [3:0]  idx_s;
   logic [15:0] base_s;

   assign idx_s = 4'(row_i);

   // Bitmap lookup; deliberately asymmetric so mirroring is visible.
   always_comb begin
      base_s = 16'h0000;
      case (idx_s)
         4'd0:    base_s = 16'h0001;
         4'd1:    base_s = 16'h0003;
         4'd2:    base_s = 16'h0007;
         4'd3:    base_s = 16'h000F;
         4'd4:    base_s = 16'h801F;
         4'd5:    base_s = 16'h403F;
         4'd6:    base_s = 16'h207F;
         4'd7:    base_s = 16'h10FF;
         4'd8:    base_s = 16'hF0F0;
         4'd9:    base_s = 16'h0F0F;
         4'd10:   base_s = 16'h3C3C;
         4'd11:   base_s = 16'h1234;
         4'd12:   base_s = 16'hA5C3;
         4'd13:   base_s = 16'h8001;
         4'd14:   base_s = 16'hFFFE;
         4'd15:   base_s = 16'h7FFF;
         default: base_s = 16'h0000;
      endcase
   end

   assign word_o = SPRITE_W'(base_s);

endmodule

// File: rtl/vga_sprite_engine.sv
// -----------------------------------------------------------------------------
// vga_sprite_engine
// Two-stage pixel pipeline that overlays NUM_SPRITES bitmap sprites on a
// one-bit track layer and (optionally) reports sprite/sprite collisions once
// per frame.
//   Stage 1: per-sprite bounding-box hit, row/col offsets, attributes.
//   Stage 2: bitmap lookup, priority colour select, collision accumulate.
// Build option: define SPRITE_COLLISION_EN to include collision detection;
// without it collision and frame_done are constant 0.
// Ports:
//   clk, rst_n              pixel clock, async active-low reset
//   h_counter, v_counter    current pixel column/row
//   video_on, bg_pixel      visible-area flag, track pixel (drawn white)
//   spr_x, spr_y            packed sprite left/top edges (slice i = sprite i)
//   spr_en, spr_flip        per-sprite enable / horizontal mirror
//   spr_rgb                 packed per-sprite colour {r,g,b}
//   vga_r, vga_g, vga_b     registered pixel colour
//   collision               per-sprite collision flags of the previous frame
//   frame_done              one-cycle pulse when collision updates
// -----------------------------------------------------------------------------
module vga_sprite_engine
   import vga_pkg::*;
#(
   parameter int NUM_SPRITES = 2,
   parameter int SPRITE_W    = DEF_SPRITE_W,
   parameter int SPRITE_H    = DEF_SPRITE_H,
   parameter int COORD_W     = DEF_COORD_W
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic [COORD_W-1:0]             h_counter,
   input  logic [COORD_W-1:0]             v_counter,
   input  logic                           video_on,
   input  logic                           bg_pixel,
   input  logic [NUM_SPRITES*COORD_W-1:0] spr_x,
   input  logic [NUM_SPRITES*COORD_W-1:0] spr_y,
   input  logic [NUM_SPRITES-1:0]         spr_en,
   input  logic [NUM_SPRITES-1:0]         spr_flip,
   input  logic [NUM_SPRITES*3-1:0]       spr_rgb,
   output logic                           vga_r,
   output logic                           vga_g,
   output logic                           vga_b,
   output logic [NUM_SPRITES-1:0]         collision,
   output logic                           frame_done
);

   localparam int ROW_W = (SPRITE_H > 1) ? $clog2(SPRITE_H) : 1;
   localparam int COL_W = (SPRITE_W > 1) ? $clog2(SPRITE_W) : 1;
   // Extents are one bit wider than the counters so x+SPRITE_W never wraps.
   localparam logic [COORD_W:0]  SPAN_W  = (COORD_W+1)'(SPRITE_W);
   localparam logic [COORD_W:0]  SPAN_H  = (COORD_W+1)'(SPRITE_H);
   localparam logic [COL_W-1:0]  COL_MAX = COL_W'(SPRITE_W - 1);

   // Stage 1
   logic [NUM_SPRITES-1:0]            hit_d, hit_q;
   logic [NUM_SPRITES-1:0][ROW_W-1:0] row_d, row_q;
   logic [NUM_SPRITES-1:0][COL_W-1:0] col_d, col_q;
   logic [NUM_SPRITES-1:0]            flip_q;
   logic [NUM_SPRITES-1:0][2:0]       rgb_q;
   logic                              von_q;
   logic                              bg_q;

   // Stage 2
   logic [SPRITE_W-1:0]               word_s [NUM_SPRITES];
   logic [NUM_SPRITES-1:0][COL_W-1:0] idx_s;
   logic [NUM_SPRITES-1:0]            opaque_s;
   logic [NUM_SPRITES-1:0]            first_s;
   logic [2:0]                        spr_col_s;
   logic [2:0]                        colour_d, colour_q;

   // Stage-1 bounding-box test and in-sprite offsets for every sprite.
   always_comb begin
      hit_d = {NUM_SPRITES{1'b0}};
      row_d = '0;
      col_d = '0;
      for (int i = 0; i < NUM_SPRITES; i++) begin
         hit_d[i] = spr_en[i]
            & ({1'b0, h_counter} >= {1'b0, spr_x[i*COORD_W +: COORD_W]})
            & ({1'b0, h_counter} <  ({1'b0, spr_x[i*COORD_W +: COORD_W]} + SPAN_W))
            & ({1'b0, v_counter} >= {1'b0, spr_y[i*COORD_W +: COORD_W]})
            & ({1'b0, v_counter} <  ({1'b0, spr_y[i*COORD_W +: COORD_W]} + SPAN_H));
         row_d[i] = ROW_W'(v_counter - spr_y[i*COORD_W +: COORD_W]);
         col_d[i] = COL_W'(h_counter - spr_x[i*COORD_W +: COORD_W]);
      end
   end

   // Stage-1 pipeline registers; sprite attributes travel with the pixel.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hit_q  <= {NUM_SPRITES{1'b0}};
         row_q  <= '0;
         col_q  <= '0;
         flip_q <= {NUM_SPRITES{1'b0}};
         rgb_q  <= '0;
         von_q  <= 1'b0;
         bg_q   <= 1'b0;
      end else begin
         hit_q  <= hit_d;
         row_q  <= row_d;
         col_q  <= col_d;
         flip_q <= spr_flip;
         rgb_q  <= spr_rgb;
         von_q  <= video_on;
         bg_q   <= bg_pixel;
      end
   end

   for (genvar g = 0; g < NUM_SPRITES; g++) begin : g_rom
      sprite_rom #(
         .SPRITE_W (SPRITE_W),
         .SPRITE_H (SPRITE_H),
         .ROW_W    (ROW_W)
      ) u_rom (
         .row_i  (row_q[g]),
         .word_o (word_s[g])
      );
   end

   // Stage-2 bitmap bit per sprite, mirrored when flip is set.
   always_comb begin
      idx_s    = '0;
      opaque_s = {NUM_SPRITES{1'b0}};
      for (int i = 0; i < NUM_SPRITES; i++) begin
         idx_s[i]    = flip_q[i] ? (COL_MAX - col_q[i]) : col_q[i];
         opaque_s[i] = hit_q[i] & word_s[i][idx_s[i]];
      end
   end

   // Stage-2 colour: lowest-index opaque sprite wins, then track, then black.
   always_comb begin
      first_s   = opaque_s & (~opaque_s + NUM_SPRITES'(1));  // isolate lowest set bit
      spr_col_s = 3'b000;
      for (int i = 0; i < NUM_SPRITES; i++) begin
         spr_col_s = spr_col_s | ({3{first_s[i]}} & rgb_q[i]);
      end
      if (!von_q) begin
         colour_d = BLACK;
      end else if (|opaque_s) begin
         colour_d = spr_col_s;
      end else if (bg_q) begin
         colour_d = WHITE;
      end else begin
         colour_d = BLACK;
      end
   end

   // Registered pixel colour.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         colour_q <= 3'b000;
      end else begin
         colour_q <= colour_d;
      end
   end

   assign vga_r = colour_q[2];
   assign vga_g = colour_q[1];
   assign vga_b = colour_q[0];

`ifdef SPRITE_COLLISION_EN
   logic                   fs_d, fs_q;
   logic [NUM_SPRITES-1:0] overlap_s;
   logic [NUM_SPRITES-1:0] acc_d, acc_q;
   logic [NUM_SPRITES-1:0] coll_d, coll_q;
   logic                   done_d, done_q;

   assign fs_d      = (h_counter == {COORD_W{1'b0}}) && (v_counter == {COORD_W{1'b0}});
   assign overlap_s = multi_hot(32'(opaque_s)) ? opaque_s : {NUM_SPRITES{1'b0}};

   // Frame start publishes the finished frame and seeds the new one with the
   // current pixel's overlap, so that overlap is never reported early.
   always_comb begin
      acc_d  = acc_q | overlap_s;
      coll_d = coll_q;
      done_d = 1'b0;
      if (fs_q) begin
         coll_d = acc_q;
         acc_d  = overlap_s;
         done_d = 1'b1;
      end else begin
         done_d = 1'b0;
      end
   end

   // Frame-start flag pipeline plus collision state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fs_q   <= 1'b0;
         acc_q  <= {NUM_SPRITES{1'b0}};
         coll_q <= {NUM_SPRITES{1'b0}};
         done_q <= 1'b0;
      end else begin
         fs_q   <= fs_d;
         acc_q  <= acc_d;
         coll_q <= coll_d;
         done_q <= done_d;
      end
   end

   assign collision  = coll_q;
   assign frame_done = done_q;
`else
   assign collision  = {NUM_SPRITES{1'b0}};
   assign frame_done = 1'b0;
`endif

endmodule
